// File: rtl/eth_pkg.sv
// Shared constants and FSM encoding for the TS-over-Ethernet transmit path.
// Also used by the receive-side CRC checker.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam int          HDR_LEN       = 14;
   localparam int          PRE_LEN       = 7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SFD,
      S_HDR,
      S_PAY,
      S_FCS,
      S_IFG
   } state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 update for one byte, LSB-first (reflected polynomial).
// Shared between the transmit framer and the receive checker.
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] c;

   always_comb begin
      c = crc_i ^ {24'h0, data_i};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_o = c;
   end

endmodule

// File: rtl/ts_eth_framer.sv
// Captures fixed-length TS packets into a two-bank buffer and sends each
// as one Ethernet II frame on a byte-wide GMII-style transmit interface.
module ts_eth_framer
   import eth_pkg::*;
#(
   parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETHERTYPE = 16'h88B5,
   parameter int          TS_LEN    = 188,
   parameter int          IFG_LEN   = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ts_data,
   input  logic        ts_valid,
   input  logic        ts_start,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
);

   localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        rd_bank_q, rd_bank_d;
   logic [1:0]  full_q, full_d;
   logic        wr_bank_q, wr_bank_d;
   logic [7:0]  wr_ptr_q, wr_ptr_d;
   logic        wr_act_q, wr_act_d;
   logic [31:0] crc_q, crc_d, crc_nxt;
   logic [15:0] frame_cnt_q, drop_cnt_q;
   logic [7:0]  rdata_q;
   logic [7:0]  bank_mem [2][256];

   logic [7:0]  rd_addr, wr_addr, hdr_byte, fcs_byte;
   logic [31:0] fcs;
   logic [1:0]  set_full, clr_full;
   logic        we, rel, drop_inc;

   // Write side: a start always restarts into a free bank or drops the packet
   always_comb begin
      we       = 1'b0;
      wr_addr  = wr_ptr_q;
      wr_bank_d = wr_bank_q;
      wr_ptr_d = wr_ptr_q;
      wr_act_d = wr_act_q;
      set_full = 2'b00;
      drop_inc = 1'b0;
      if (ts_valid && ts_start) begin
         if (&full_q) begin
            wr_act_d = 1'b0;
            drop_inc = 1'b1;
         end else begin
            we        = 1'b1;
            wr_addr   = 8'd0;
            wr_bank_d = full_q[0];
            wr_ptr_d  = 8'd1;
            wr_act_d  = 1'b1;
         end
      end else if (ts_valid && wr_act_q) begin
         we = 1'b1;
         if (wr_ptr_q == 8'(TS_LEN - 1)) begin
            set_full[wr_bank_q] = 1'b1;
            wr_act_d = 1'b0;
         end else begin
            wr_ptr_d = wr_ptr_q + 8'd1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 8'd1;
      rd_bank_d = rd_bank_q;
      rel       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (|full_q) begin
               state_d   = S_PRE;
               rd_bank_d = ~full_q[0];
            end
         end
         S_PRE: if (cnt_q == 8'(PRE_LEN - 1)) begin
            state_d = S_SFD;
            cnt_d   = 8'd0;
         end
         S_SFD: begin
            state_d = S_HDR;
            cnt_d   = 8'd0;
         end
         S_HDR: if (cnt_q == 8'(HDR_LEN - 1)) begin
            state_d = S_PAY;
            cnt_d   = 8'd0;
         end
         S_PAY: if (cnt_q == 8'(TS_LEN - 1)) begin
            state_d = S_FCS;
            cnt_d   = 8'd0;
         end
         S_FCS: if (cnt_q == 8'd3) begin
            state_d = S_IFG;
            cnt_d   = 8'd0;
            rel     = 1'b1;
         end
         S_IFG: if (cnt_q == 8'(IFG_LEN - 1)) begin
            cnt_d = 8'd0;
            if (|full_q) begin
               state_d   = S_PRE;
               rd_bank_d = ~full_q[0];
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign clr_full = rel ? (2'b01 << rd_bank_q) : 2'b00;
   assign full_d   = (full_q | set_full) & ~clr_full;

   // Address runs one byte ahead so PAY streams without a bubble
   assign rd_addr = (state_q == S_PAY) ? cnt_q + 8'd1 : 8'd0;

   always_ff @(posedge clk) begin
      if (we) bank_mem[wr_bank_d][wr_addr] <= ts_data;
      rdata_q <= bank_mem[rd_bank_q][rd_addr];
   end

   always_comb begin
      hdr_byte = 8'h00;
      for (int i = 0; i < HDR_LEN; i++) begin
         if (cnt_q == 8'(i)) hdr_byte = HDR[111 - 8*i -: 8];
      end
   end

   assign fcs = ~crc_q;

   always_comb begin
      unique case (cnt_q[1:0])
         2'd0: fcs_byte = fcs[7:0];
         2'd1: fcs_byte = fcs[15:8];
         2'd2: fcs_byte = fcs[23:16];
         default: fcs_byte = fcs[31:24];
      endcase
   end

   always_comb begin
      unique case (state_q)
         S_PRE:   gmii_txd = PREAMBLE_BYTE;
         S_SFD:   gmii_txd = SFD_BYTE;
         S_HDR:   gmii_txd = hdr_byte;
         S_PAY:   gmii_txd = rdata_q;
         S_FCS:   gmii_txd = fcs_byte;
         default: gmii_txd = 8'h00;
      endcase
   end

   assign gmii_tx_en = (state_q != S_IDLE) && (state_q != S_IFG);
   assign busy       = (state_q != S_IDLE);
   assign frame_cnt  = frame_cnt_q;
   assign drop_cnt   = drop_cnt_q;

   eth_crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i (gmii_txd),
      .crc_o  (crc_nxt)
   );

   always_comb begin
      crc_d = crc_q;
      if (state_q == S_HDR || state_q == S_PAY) crc_d = crc_nxt;
      else if (state_q != S_FCS) crc_d = CRC_INIT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         rd_bank_q   <= 1'b0;
         full_q      <= 2'b00;
         wr_bank_q   <= 1'b0;
         wr_ptr_q    <= 8'd0;
         wr_act_q    <= 1'b0;
         crc_q       <= CRC_INIT;
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_act_q    <= wr_act_d;
         crc_q       <= crc_d;
         frame_cnt_q <= frame_cnt_q + {15'd0, rel};
         if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_ts_eth_framer.sv
// Directed bench for ts_eth_framer: frames are rebuilt from the payload
// pattern with a bit-serial CRC model and compared byte by byte.
module tb_ts_eth_framer;

   localparam int FRAME_LEN = 214;
   localparam logic [7:0] HDR_B [14] = '{
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
      8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
      8'h88, 8'hB5};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  ts_data = 8'h00;
   logic        ts_valid = 1'b0;
   logic        ts_start = 1'b0;
   logic [7:0]  gmii_txd;
   logic        gmii_tx_en;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   logic [7:0] rx[$];
   logic [7:0] last_frame[$];
   int         exp_q[$];
   int         frames_done = 0;
   int         gap = 0;
   int         last_gap = 0;
   bit         prev_en = 1'b0;
   bit         mon_en = 1'b1;

   ts_eth_framer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ts_data    (ts_data),
      .ts_valid   (ts_valid),
      .ts_start   (ts_start),
      .gmii_txd   (gmii_txd),
      .gmii_tx_en (gmii_tx_en),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .drop_cnt   (drop_cnt)
   );

   always #4 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
         else r = r >> 1;
      end
      return r;
   endfunction

   task automatic end_frame();
      logic [7:0]  ef [FRAME_LEN];
      logic [31:0] c;
      logic [7:0]  seed;
      int          bad;
      int          first;
      frames_done++;
      last_frame = rx;
      chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() == 0) return;
      seed = 8'(exp_q.pop_front());
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i < 7) ef[i] = 8'h55;
         else if (i == 7) ef[i] = 8'hD5;
         else if (i < 22) ef[i] = HDR_B[i-8];
         else if (i < 210) ef[i] = seed + 8'(i - 22);
         else ef[i] = 8'h00;
      end
      c = 32'hFFFFFFFF;
      for (int i = 8; i < 210; i++) c = crc_byte(c, ef[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) ef[210+k] = c[8*k +: 8];
      chk("frame_len", rx.size(), FRAME_LEN);
      bad = 0;
      first = -1;
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i >= rx.size() || rx[i] !== ef[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL frame_bytes seed=%h: %0d bytes differ, first at %0d got %h expected %h",
                  seed, bad, first,
                  (first < rx.size()) ? rx[first] : 8'hxx, ef[first]);
      end
      if (rx.size() == FRAME_LEN) begin
         c = 32'hFFFFFFFF;
         for (int i = 8; i < FRAME_LEN; i++) c = crc_byte(c, rx[i]);
         chk("fcs_residue", c, 32'hDEBB20E3);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n || !mon_en) begin
         rx.delete();
         prev_en = 1'b0;
         gap = 0;
         if (!rst_n) frames_done = 0;
      end else begin
         if (gmii_tx_en) begin
            if (!prev_en) last_gap = gap;
            rx.push_back(gmii_txd);
         end else begin
            chk("idle_txd", {24'd0, gmii_txd}, 32'd0);
            if (prev_en) begin
               end_frame();
               rx.delete();
               gap = 1;
            end else begin
               gap++;
            end
         end
         prev_en = gmii_tx_en;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ts_valid = 1'b0;
      ts_start = 1'b0;
      ts_data  = 8'h00;
      rst_n    = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("reset_tx_en", {31'd0, gmii_tx_en}, 32'd0);
      chk("reset_txd", {24'd0, gmii_txd}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
   endtask

   task automatic send_pkt(input logic [7:0] seed, input int n,
                           input bit with_start);
      for (int i = 0; i < n; i++) begin
         ts_valid = 1'b1;
         ts_start = with_start && (i == 0);
         ts_data  = seed + 8'(i);
         tick();
      end
      ts_valid = 1'b0;
      ts_start = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int b;
      b = 0;
      while (frames_done < n && b < 2000) begin
         tick();
         b++;
      end
      chk("frames_seen", frames_done, n);
   endtask

   initial begin
      // Single packet, latency and literal frame contents
      do_reset();
      exp_q.push_back(8'h00);
      send_pkt(8'h00, 188, 1'b1);
      chk("latency_early", {31'd0, gmii_tx_en}, 32'd0);
      tick();
      chk("latency_tx_en", {31'd0, gmii_tx_en}, 32'd1);
      chk("first_txd", {24'd0, gmii_txd}, 32'h55);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      wait_frames(1);
      chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("lit_pre6", {24'd0, last_frame[6]}, 32'h55);
      chk("lit_sfd", {24'd0, last_frame[7]}, 32'hD5);
      chk("lit_dst0", {24'd0, last_frame[8]}, 32'hFF);
      chk("lit_dst5", {24'd0, last_frame[13]}, 32'hFF);
      chk("lit_src0", {24'd0, last_frame[14]}, 32'h02);
      chk("lit_src5", {24'd0, last_frame[19]}, 32'h01);
      chk("lit_type0", {24'd0, last_frame[20]}, 32'h88);
      chk("lit_type1", {24'd0, last_frame[21]}, 32'hB5);
      chk("lit_pay0", {24'd0, last_frame[22]}, 32'h00);
      chk("lit_pay187", {24'd0, last_frame[209]}, 32'hBB);

      // Two packets 20 cycles apart: back-to-back frames with minimum gap
      do_reset();
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h40);
      send_pkt(8'h10, 188, 1'b1);
      repeat (20) tick();
      send_pkt(8'h40, 188, 1'b1);
      wait_frames(2);
      chk("t2_gap", last_gap, 12);
      chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
      chk("t2_drop_cnt", {16'd0, drop_cnt}, 32'd0);

      // Three packets without gaps: the third finds both banks full
      do_reset();
      exp_q.push_back(8'h20);
      exp_q.push_back(8'h30);
      send_pkt(8'h20, 188, 1'b1);
      send_pkt(8'h30, 188, 1'b1);
      send_pkt(8'h50, 188, 1'b1);
      wait_frames(2);
      repeat (400) tick();
      chk("t3_no_third", frames_done, 2);
      chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd2);
      chk("t3_drop_cnt", {16'd0, drop_cnt}, 32'd1);

      // Stray bytes, restart after 100 bytes, trailing bytes past TS_LEN
      do_reset();
      exp_q.push_back(8'h90);
      send_pkt(8'hE0, 5, 1'b0);
      send_pkt(8'h77, 100, 1'b1);
      send_pkt(8'h90, 188, 1'b1);
      send_pkt(8'h33, 10, 1'b0);
      wait_frames(1);
      repeat (300) tick();
      chk("t4_one_frame", frames_done, 1);
      chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("t4_drop_cnt", {16'd0, drop_cnt}, 32'd0);

      // Reset in the middle of payload byte 50
      do_reset();
      send_pkt(8'hA0, 188, 1'b1);
      tick();
      chk("t5_started", {31'd0, gmii_tx_en}, 32'd1);
      repeat (72) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_async_tx_en", {31'd0, gmii_tx_en}, 32'd0);
      chk("t5_async_txd", {24'd0, gmii_txd}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (300) tick();
      chk("t5_no_frame", frames_done, 0);
      chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("t5_idle_busy", {31'd0, busy}, 32'd0);
      exp_q.push_back(8'hC0);
      send_pkt(8'hC0, 188, 1'b1);
      wait_frames(1);
      chk("t5_frame_cnt_after", {16'd0, frame_cnt}, 32'd1);

      // Drop counter saturation with both banks held full
      mon_en = 1'b0;
      do_reset();
      force dut.full_q = 2'b11;
      ts_valid = 1'b1;
      ts_start = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("t6_drop_fffe", {16'd0, drop_cnt}, 32'h0000FFFE);
      repeat (6) @(posedge clk);
      #1;
      chk("t6_drop_sat", {16'd0, drop_cnt}, 32'h0000FFFF);
      ts_valid = 1'b0;
      ts_start = 1'b0;
      release dut.full_q;
      do_reset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ts_eth_framer.md
Name: ts_eth_framer

Overview:
- Downstream consumer of ts_packet_gen, sitting between it and the RGMII DDR output stage.
- Captures fixed-length TS packets (ts_data/ts_valid/ts_start) into a two-bank buffer.
- Emits each captured packet as one raw Ethernet II frame on a byte-wide GMII-style interface: preamble, SFD, MAC header, payload, FCS, inter-frame gap.
- Runs entirely in the 125 MHz transmit clock domain.

Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, sent MSB byte first.
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC (locally administered), sent MSB byte first.
- ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first.
- TS_LEN, 188, payload bytes per packet; legal range 46..255.
- IFG_LEN, 12, idle cycles forced after each FCS; minimum 12.

Ports:
- clk  in  1  transmit byte clock, 125 MHz
- rst_n  in  1  asynchronous active-low reset
- ts_data  in  8  packet byte from generator
- ts_valid  in  1  ts_data qualifier
- ts_start  in  1  first byte of a packet; valid only together with ts_valid
- gmii_txd  out  8  transmit byte
- gmii_tx_en  out  1  frame-active qualifier for gmii_txd
- busy  out  1  high when not in IDLE
- frame_cnt  out  16  frames fully transmitted, wraps
- drop_cnt  out  16  packets discarded, saturates at 16'hFFFF

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. On reset assertion all outputs go to 0, both banks become empty, the write pointer clears and the FSM goes to IDLE.
- Buffer:
  - Two banks of 256x8 synchronous-read RAM, each with a full flag.
  - The write side fills one bank and the read side drains the other.
  - A bank becomes full on the edge that writes byte TS_LEN-1.
  - The read side clears the full flag on the edge that leaves FCS.
- Write rules:
  - ts_valid && ts_start: restart at byte 0 into a free bank. Any partially written bank is discarded silently, with no drop_cnt increment.
  - ts_valid without a preceding start: ignored.
  - Bytes beyond TS_LEN before the next start: ignored.
  - Both banks full, or the only free bank is being read, when ts_start arrives: the whole packet is discarded and drop_cnt increments once.
  - A write completion and a read release on the same edge are both honoured.
- FSM states and per-state byte counts: IDLE, PRE (7 bytes of 8'h55), SFD (1 byte of 8'hD5), HDR (14 bytes: DST, SRC, ETHERTYPE), PAY (TS_LEN bytes from the bank), FCS (4 bytes), IFG (IFG_LEN cycles).
- gmii_tx_en is high in PRE..FCS and low in IDLE and IFG.
- gmii_txd is 8'h00 whenever gmii_tx_en is low.
- Leaving IDLE: on the first edge at which any bank is full. gmii_tx_en rises on that edge.
  - Latency: the last payload byte is written at edge N; the first preamble byte appears after edge N+1.
- Bank order: banks are transmitted in completion order.
- RAM read: the address is issued one cycle ahead (during the last HDR byte) so PAY outputs one byte per cycle with no bubble.
- FCS:
  - CRC-32 with reflected polynomial 32'hEDB88320, initial value 32'hFFFFFFFF.
  - Covers HDR and PAY bytes.
  - The transmitted value is the bitwise complement of the CRC, least-significant byte first.
- Frame timing: a total of 8+14+TS_LEN+4 gmii_tx_en cycles, which is 214 for TS_LEN=188. No padding is needed because TS_LEN ≥ 46.
- After IFG: go back to PRE if another bank is full, otherwise IDLE. Back-to-back frames are separated by exactly IFG_LEN idle cycles.
- frame_cnt increments on the FCS→IFG transition.
- Reset mid-frame: gmii_tx_en drops immediately (asynchronously). The frame is abandoned and not counted.

Decomposition:
- Shared package, eth_pkg:
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, HDR_LEN=14, PRE_LEN=7.
  - FSM state enum.
- One sub-module: eth_crc32_d8, a combinational next-CRC function for an 8-bit input. It is reused later by the receive path.
- The bank RAM is inferred inline.

Test Plan:
- One packet of bytes 0..187 after reset:
  - tx_en runs for 214 cycles.
  - Bytes 0-6 = 55, byte 7 = D5, bytes 8-13 = FF, bytes 14-19 = 02 00 00 00 00 01, bytes 20-21 = 88 B5, bytes 22-209 = 00..BB.
  - FCS matches the bench CRC model.
  - Check receiver-style CRC over bytes 8-213 = residue 32'hDEBB20E3 and frame_cnt=1.
- Two packets 20 cycles apart: two frames with exactly 12 tx_en-low cycles between them; frame_cnt=2, drop_cnt=0.
- Three packets back-to-back with no gap: frames 1 and 2 transmitted, packet 3 dropped, drop_cnt=1.
- ts_start re-asserted after 100 bytes, then a full packet: exactly one frame whose payload is the second packet only; drop_cnt=0.
- rst_n pulsed low during PAY byte 50: tx_en=0 immediately. After release, no frame is emitted until a new packet arrives, and frame_cnt=0.
- 65540 forced drops with the read side blocked: drop_cnt saturates at FFFF.
